gp_reg_bank: RTL and testbench

//   Parametrised general-purpose register bank driven by one-hot write (GRin) and read (GRout) vectors.

---
 rtl/gp_reg_bank.sv | 127 ++++++++++++
 tb/tb_gp_reg_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_reg_bank.sv
// ---------------------------------------------------------------------------
// gp_reg_bank
//   General-purpose register bank. Registers are written from the bus using a
//   one-hot GRin vector and read combinationally using a one-hot GRout vector.
//   A sweep clear zeroes one register per cycle while clr_busy is high.
//   Any multi-hot select vector sets the sticky onehot_err flag.
//
// Ports
//   clk          rising-edge clock for all state
//   reg_clear_n  asynchronous active-low reset
//   sw_clear     start a sweep clear of every register
//   BAout        base-address read mode; R0 reads 0 when ZERO_REG_BA=1
//   BusMuxOut    write data from the bus
//   GRin         one-hot write enables, bit i -> Ri
//   GRout        one-hot read selects, bit i -> Ri
//   err_clr      clears onehot_err
//   BusMuxIn     read data to the bus mux
//   clr_busy     high while the sweep clear runs
//   onehot_err   sticky multi-hot select flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | normal operation, writes and reads enabled
// SWEEP | clearing R[cnt] each cycle, writes dropped, BusMuxIn forced 0
// ---------------------------------------------------------------------------
module gp_reg_bank #(
  parameter int NUM_REGS    = 16,
  parameter int DATA_W      = 32,
  parameter int ZERO_REG_BA = 1
) (
  input  logic                clk,
  input  logic                reg_clear_n,
  input  logic                sw_clear,
  input  logic                BAout,
  input  logic [DATA_W-1:0]   BusMuxOut,
  input  logic [NUM_REGS-1:0] GRin,
  input  logic [NUM_REGS-1:0] GRout,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   BusMuxIn,
  output logic                clr_busy,
  output logic                onehot_err
);

  localparam int CW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_REGS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_data;
  logic              grin_multi, grout_multi;
  logic              grin_onehot, grout_onehot;

  // A vector with more than one bit set keeps a bit after clearing its lowest one.
  function automatic logic multi_hot(input logic [NUM_REGS-1:0] v);
    return (v & (v - NUM_REGS'(1))) != '0;
  endfunction

  assign grin_multi   = multi_hot(GRin);
  assign grout_multi  = multi_hot(GRout);
  assign grin_onehot  = (GRin != '0) && !grin_multi;
  assign grout_onehot = (GRout != '0) && !grout_multi;

  always_ff @(posedge clk or negedge reg_clear_n) begin
    if (!reg_clear_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sw_clear) state_nxt = SWEEP;
      SWEEP:   if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == SWEEP);

  // A write sampled together with sw_clear still lands; the sweep clears it later.
  always_ff @(posedge clk or negedge reg_clear_n) begin
    if (!reg_clear_n) begin
      cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grin_onehot) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (GRin[i]) regs[i] <= BusMuxOut;
          end
          if (sw_clear) cnt <= '0;
        end
        SWEEP: begin
          regs[cnt] <= '0;
          if (cnt == LAST) cnt <= '0;
          else             cnt <= cnt + CW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // OR-reduction mux; only trusted when GRout is exactly one-hot.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (GRout[i]) rd_data = rd_data | regs[i];
  end

  always_comb begin
    BusMuxIn = '0;
    if (state == IDLE && grout_onehot &&
        !((ZERO_REG_BA != 0) && GRout[0] && BAout))
      BusMuxIn = rd_data;
  end

  // A new violation wins over err_clr in the same cycle.
  always_ff @(posedge clk or negedge reg_clear_n) begin
    if (!reg_clear_n)                onehot_err <= 1'b0;
    else if (grin_multi || grout_multi) onehot_err <= 1'b1;
    else if (err_clr)                onehot_err <= 1'b0;
  end

endmodule

// File: tb/tb_gp_reg_bank.sv
module tb_gp_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // 16 x 32 instance
  logic        a_rst_n, a_sw_clear, a_ba, a_err_clr;
  logic [31:0] a_wd, a_rd;
  logic [15:0] a_grin, a_grout;
  logic        a_busy, a_oerr;

  // 8 x 16 instance
  logic        b_rst_n, b_sw_clear, b_ba, b_err_clr;
  logic [15:0] b_wd, b_rd;
  logic [7:0]  b_grin, b_grout;
  logic        b_busy, b_oerr;

  logic [31:0] ma [16];
  logic [15:0] mb [8];

  logic [31:0] sb_q [$];
  string       sb_tag [$];

  gp_reg_bank #(.NUM_REGS(16), .DATA_W(32), .ZERO_REG_BA(1)) u_dut_a (
    .clk(clk), .reg_clear_n(a_rst_n), .sw_clear(a_sw_clear), .BAout(a_ba),
    .BusMuxOut(a_wd), .GRin(a_grin), .GRout(a_grout), .err_clr(a_err_clr),
    .BusMuxIn(a_rd), .clr_busy(a_busy), .onehot_err(a_oerr)
  );

  gp_reg_bank #(.NUM_REGS(8), .DATA_W(16), .ZERO_REG_BA(1)) u_dut_b (
    .clk(clk), .reg_clear_n(b_rst_n), .sw_clear(b_sw_clear), .BAout(b_ba),
    .BusMuxOut(b_wd), .GRin(b_grin), .GRout(b_grout), .err_clr(b_err_clr),
    .BusMuxIn(b_rd), .clr_busy(b_busy), .onehot_err(b_oerr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_q.push_back(exp);
    sb_tag.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    logic [31:0] e;
    string       t;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = sb_tag.pop_front();
      check(t, act, e);
    end
  endtask

  task automatic a_write(input int idx, input logic [31:0] d);
    a_grin = 16'(1) << idx;
    a_wd   = d;
    tick();
    a_grin = '0;
    ma[idx] = d;
  endtask

  task automatic a_read(input int idx, input logic ba, input string tag);
    a_grout = 16'(1) << idx;
    a_ba    = ba;
    sb_push(tag, (ba && idx == 0) ? 32'h0 : ma[idx]);
    @(negedge clk);
    sb_pop(a_rd);
    tick();
    a_grout = '0;
    a_ba    = 1'b0;
  endtask

  task automatic b_write(input int idx, input logic [15:0] d);
    b_grin = 8'(1) << idx;
    b_wd   = d;
    tick();
    b_grin = '0;
    mb[idx] = d;
  endtask

  task automatic b_read(input int idx, input logic ba, input string tag);
    b_grout = 8'(1) << idx;
    b_ba    = ba;
    sb_push(tag, (ba && idx == 0) ? 32'h0 : {16'h0, mb[idx]});
    @(negedge clk);
    sb_pop({16'h0, b_rd});
    tick();
    b_grout = '0;
    b_ba    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    a_rst_n = 0; a_sw_clear = 0; a_ba = 0; a_err_clr = 0; a_wd = '0; a_grin = '0; a_grout = '0;
    b_rst_n = 0; b_sw_clear = 0; b_ba = 0; b_err_clr = 0; b_wd = '0; b_grin = '0; b_grout = '0;
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 8; i++)  mb[i] = '0;

    // reset state
    a_grout = 16'h0020;
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy_a", {31'h0, a_busy}, 32'h0);
    check("rst_err_a",  {31'h0, a_oerr}, 32'h0);
    check("rst_rd_a",   a_rd, 32'h0);
    check("rst_busy_b", {31'h0, b_busy}, 32'h0);
    tick();
    a_rst_n = 1; b_rst_n = 1; a_grout = '0;
    tick();

    // test 1: basic write/read
    a_write(5, 32'hDEADBEEF);
    a_read(5, 1'b0, "t1_r5");
    check("t1_err", {31'h0, a_oerr}, 32'h0);

    // read-before-write in the same cycle
    a_grin = 16'h0020; a_wd = 32'h1111_2222; a_grout = 16'h0020;
    sb_push("rbw_old", ma[5]);
    @(negedge clk);
    sb_pop(a_rd);
    tick();
    a_grin = '0; a_grout = '0; ma[5] = 32'h1111_2222;
    a_read(5, 1'b0, "rbw_new");

    // test 2: R0 under BAout
    a_write(0, 32'h0000_1234);
    a_read(0, 1'b1, "t2_ba1");
    a_read(0, 1'b0, "t2_ba0");

    // test 3: multi-hot GRin, err_clr, multi-hot GRout
    a_grin = 16'h0021; a_wd = 32'hFFFF_FFFF;
    tick();
    a_grin = '0;
    check("t3_err_set", {31'h0, a_oerr}, 32'h1);
    a_read(0, 1'b0, "t3_r0");
    a_read(5, 1'b0, "t3_r5");
    a_err_clr = 1;
    tick();
    a_err_clr = 0;
    check("t3_err_clr", {31'h0, a_oerr}, 32'h0);
    a_grout = 16'h0003;
    sb_push("t3_multi_rd", 32'h0);
    @(negedge clk);
    sb_pop(a_rd);
    tick();
    check("t3_err_rd", {31'h0, a_oerr}, 32'h1);
    a_err_clr = 1;
    tick();
    check("t3_clr_vs_set", {31'h0, a_oerr}, 32'h1);
    a_grout = '0;
    tick();
    check("t3_err_clr2", {31'h0, a_oerr}, 32'h0);
    a_err_clr = 0;

    // test 4: full sweep clear
    for (int i = 0; i < 16; i++) a_write(i, 32'hC0DE_0000 + 32'(i) + 32'd1);
    a_read(9, 1'b0, "t4_pre_r9");
    a_grout = 16'h0020;
    a_sw_clear = 1;
    tick();
    a_sw_clear = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t4_busy", {31'h0, a_busy}, 32'h1);
      sb_push("t4_rd_sweep", 32'h0);
      sb_pop(a_rd);
      tick();
    end
    check("t4_busy_done", {31'h0, a_busy}, 32'h0);
    a_grout = '0;
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 16; i++) a_read(i, 1'b0, "t4_clr");

    // test 5: writes and sw_clear during sweep; write+sw_clear same cycle
    a_write(3, 32'h0000_0033);
    a_write(10, 32'h0000_00AA);
    a_grin = 16'h0080; a_wd = 32'h0000_7777; a_sw_clear = 1;
    tick();
    a_grin = '0; a_sw_clear = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8)  begin a_grin = 16'h0008; a_wd = 32'hA5A5_A5A5; end
      if (k == 9)  a_grin = '0;
      if (k == 10) a_sw_clear = 1;
      if (k == 11) a_sw_clear = 0;
      @(negedge clk);
      check("t5_busy", {31'h0, a_busy}, 32'h1);
      tick();
    end
    check("t5_busy_done", {31'h0, a_busy}, 32'h0);
    check("t5_err", {31'h0, a_oerr}, 32'h0);
    tick();
    check("t5_no_resweep", {31'h0, a_busy}, 32'h0);
    for (int i = 0; i < 16; i++) ma[i] = '0;
    a_read(3, 1'b0, "t5_r3");
    a_read(7, 1'b0, "t5_r7");
    a_read(10, 1'b0, "t5_r10");

    // test 6: reset mid-sweep
    for (int i = 0; i < 16; i++) a_write(i, 32'h5A00_0000 + 32'(i) + 32'd1);
    a_sw_clear = 1;
    tick();
    a_sw_clear = 0;
    repeat (7) tick();
    a_grout = 16'h8000;
    #2;
    a_rst_n = 0;
    #1;
    check("t6_busy_abort", {31'h0, a_busy}, 32'h0);
    check("t6_rd_abort", a_rd, 32'h0);
    tick();
    a_rst_n = 1;
    a_grout = '0;
    tick();
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 16; i++) a_read(i, 1'b0, "t6_clr");

    // 8 x 16 instance: tests 1, 2 and 4
    b_write(5, 16'hBEEF);
    b_read(5, 1'b0, "b_t1_r5");
    check("b_t1_err", {31'h0, b_oerr}, 32'h0);
    b_write(0, 16'h1234);
    b_read(0, 1'b1, "b_t2_ba1");
    b_read(0, 1'b0, "b_t2_ba0");
    for (int i = 0; i < 8; i++) b_write(i, 16'hB000 + 16'(i) + 16'd1);
    b_read(7, 1'b0, "b_t4_pre_r7");
    b_sw_clear = 1;
    tick();
    b_sw_clear = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b_t4_busy", {31'h0, b_busy}, 32'h1);
      tick();
    end
    check("b_t4_busy_done", {31'h0, b_busy}, 32'h0);
    for (int i = 0; i < 8; i++) mb[i] = '0;
    for (int i = 0; i < 8; i++) b_read(i, 1'b0, "b_t4_clr");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
